// File: rtl/bp_fpga_host_pkg.sv
// ============================================================================
// Module : bp_fpga_host_pkg
// Brief  : NBF opcode/state enums, packed packet layout, write-data replication.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_fpga_host_pkg;

  localparam int c_nbf_opcode_width = 8;
  localparam int c_nbf_addr_width   = 64;
  localparam int c_nbf_data_width   = 64;

  typedef enum logic [7:0] {
    e_nbf_wr8    = 8'h00,
    e_nbf_wr16   = 8'h01,
    e_nbf_wr32   = 8'h02,
    e_nbf_wr64   = 8'h03,
    e_nbf_fence  = 8'hFE,
    e_nbf_finish = 8'hFF
  } bp_nbf_opcode_e;

  typedef enum logic [2:0] {
    e_ready  = 3'd0,
    e_send   = 3'd1,
    e_fence  = 3'd2,
    e_finish = 3'd3,
    e_done   = 3'd4
  } bp_nbf_loader_state_e;

  typedef struct packed {
    logic [c_nbf_opcode_width-1:0] opcode;
    logic [c_nbf_addr_width-1:0]   addr;
    logic [c_nbf_data_width-1:0]   data;
  } bp_nbf_s;

  // Narrow writes are replicated so the byte lanes the slave samples all see the payload
  function automatic logic [c_nbf_data_width-1:0] bp_nbf_replicate(
    input logic [c_nbf_data_width-1:0] d,
    input logic [1:0]                  size
  );
    case (size)
      2'd0:    return {8{d[7:0]}};
      2'd1:    return {4{d[15:0]}};
      2'd2:    return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
// ============================================================================
// Module : bsg_counter_up_down
// Brief  : Saturation-free up/down counter, one step per direction per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_counter_up_down #(
  parameter  int max_val_p    = 8,
  parameter  int init_val_p   = 0,
  localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    up_i,
  input  logic                    down_i,
  output logic [ptr_width_lp-1:0] count_o
);

  logic [ptr_width_lp-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      count_d = count_q + 1'b1;
    end else if (down_i && !up_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= ptr_width_lp'(init_val_p);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bp_fpga_nbf_loader.sv
// ============================================================================
// Module : bp_fpga_nbf_loader
// Brief  : Turns NBF packets into I/O write commands; tracks acks, runs fence/finish.
//          Define BP_NBF_CHECKSUM_EN for a running XOR of the written data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_fpga_nbf_loader
  import bp_fpga_host_pkg::*;
#(
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 64,
  parameter int nbf_data_width_p   = 64,
  parameter int nbf_in_width_p     = 192,
  parameter int max_outstanding_p  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        nbf_v_i,
  input  logic [nbf_in_width_p-1:0]   nbf_i,
  output logic                        nbf_yumi_o,
  output logic                        cmd_v_o,
  input  logic                        cmd_ready_and_i,
  output logic [nbf_addr_width_p-1:0] cmd_addr_o,
  output logic [1:0]                  cmd_size_o,
  output logic [nbf_data_width_p-1:0] cmd_data_o,
  input  logic                        resp_v_i,
  output logic                        resp_ready_and_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [nbf_data_width_p-1:0] checksum_o
);

  localparam int pkt_width_lp = $bits(bp_nbf_s);
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

  bp_nbf_loader_state_e state_d, state_q;
  logic [nbf_addr_width_p-1:0] addr_d, addr_q;
  logic [nbf_data_width_p-1:0] data_d, data_q;
  logic [1:0]                  size_d, size_q;
  logic                        err_d, err_q;
  logic [cnt_width_lp-1:0]     outstanding;
  bp_nbf_s                     pkt;
  logic                        cmd_fire, ack_take, ack_stray;

  assign pkt = nbf_i[pkt_width_lp-1:0];

  if (nbf_in_width_p > pkt_width_lp) begin : g_unused_upper
    logic unused_upper;
    assign unused_upper = ^nbf_i[nbf_in_width_p-1:pkt_width_lp];
  end

  assign cmd_v_o    = (state_q == e_send) && (outstanding < cnt_width_lp'(max_outstanding_p));
  assign cmd_fire   = cmd_v_o && cmd_ready_and_i;
  // A same-cycle send covers an ack that arrives while the counter reads zero
  assign ack_take   = resp_v_i && ((outstanding != '0) || cmd_fire);
  assign ack_stray  = resp_v_i && (outstanding == '0) && !cmd_fire;

  bsg_counter_up_down #(
    .max_val_p  (max_outstanding_p),
    .init_val_p (0)
  ) u_outstanding (
    .clk_i   (clk),
    .reset_i (reset),
    .up_i    (cmd_fire),
    .down_i  (ack_take),
    .count_o (outstanding)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    size_d     = size_q;
    err_d      = err_q || ack_stray;
    nbf_yumi_o = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      e_ready: begin
        if (nbf_v_i) begin
          nbf_yumi_o = 1'b1;
          case (pkt.opcode)
            e_nbf_wr8, e_nbf_wr16, e_nbf_wr32, e_nbf_wr64: begin
              addr_d  = pkt.addr;
              data_d  = pkt.data;
              size_d  = pkt.opcode[1:0];
              state_d = e_send;
            end
            e_nbf_fence:  state_d = e_fence;
            e_nbf_finish: state_d = e_finish;
            default:      err_d   = 1'b1;
          endcase
        end
      end
      e_send: begin
        if (cmd_fire) state_d = e_ready;
      end
      e_fence: begin
        if (outstanding == '0) state_d = e_ready;
      end
      e_finish: begin
        done_o = (outstanding == '0);
        if (outstanding == '0) state_d = e_done;
      end
      e_done: begin
        done_o = 1'b1;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= e_ready;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

  assign cmd_addr_o       = addr_q;
  assign cmd_size_o       = size_q;
  assign cmd_data_o       = bp_nbf_replicate(data_q, size_q);
  assign resp_ready_and_o = 1'b1;
  assign err_o            = err_q;

`ifdef BP_NBF_CHECKSUM_EN
  logic [nbf_data_width_p-1:0] checksum_d, checksum_q;

  always_comb begin
    checksum_d = checksum_q;
    if (cmd_fire) checksum_d = checksum_q ^ cmd_data_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_fpga_nbf_loader.sv
// ============================================================================
// Module : tb_bp_fpga_nbf_loader
// Brief  : Random and directed stimulus against a transaction-level loader model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_fpga_nbf_loader;

  logic         clk;
  logic         reset;
  logic         nbf_v_i;
  logic [191:0] nbf_i;
  logic         nbf_yumi_o;
  logic         cmd_v_o;
  logic         cmd_ready_and_i;
  logic [63:0]  cmd_addr_o;
  logic [1:0]   cmd_size_o;
  logic [63:0]  cmd_data_o;
  logic         resp_v_i;
  logic         resp_ready_and_o;
  logic         done_o;
  logic         err_o;
  logic [63:0]  checksum_o;

  bp_fpga_nbf_loader dut (
    .clk              (clk),
    .reset            (reset),
    .nbf_v_i          (nbf_v_i),
    .nbf_i            (nbf_i),
    .nbf_yumi_o       (nbf_yumi_o),
    .cmd_v_o          (cmd_v_o),
    .cmd_ready_and_i  (cmd_ready_and_i),
    .cmd_addr_o       (cmd_addr_o),
    .cmd_size_o       (cmd_size_o),
    .cmd_data_o       (cmd_data_o),
    .resp_v_i         (resp_v_i),
    .resp_ready_and_o (resp_ready_and_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .checksum_o       (checksum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event @%0t", name, $time);
  endtask

  // Replication as multiplication by a lane-broadcast constant
  function automatic logic [63:0] rep(input logic [63:0] d, input int sz);
    case (sz)
      0:       return 64'(d[7:0])  * 64'h0101010101010101;
      1:       return 64'(d[15:0]) * 64'h0001000100010001;
      2:       return 64'(d[31:0]) * 64'h0000000100000001;
      default: return d;
    endcase
  endfunction

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } cmd_t;

  cmd_t        exp_q[$];
  int          mo;
  bit          err_exp, fin_seen, fence_blk;
  logic [63:0] cs_exp;
  int          n_acc, n_yumi, n_fence_yumi;

  bit ack_en, force_ack;
  int ack_pct, rdy_pct;

  always @(negedge clk) begin
    if (reset) begin
      resp_v_i = 1'b0;
    end else if (force_ack) begin
      resp_v_i  = 1'b1;
      force_ack = 1'b0;
    end else begin
      resp_v_i = ack_en && (mo > 0) && ($urandom_range(99) < ack_pct);
    end
    cmd_ready_and_i = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin : monitor
    bit   acc, ack, idle, exp_cmd_v;
    cmd_t c;
    #3;
    if (reset) begin
      exp_q.delete();
      mo = 0; err_exp = 0; fin_seen = 0; fence_blk = 0; cs_exp = '0;
    end else begin
      acc  = cmd_v_o && cmd_ready_and_i;
      ack  = resp_v_i;
      idle = (exp_q.size() == 0) && !fence_blk && !fin_seen;
      exp_cmd_v = (exp_q.size() > 0) && (mo < 8);
      check("resp_ready", 64'(resp_ready_and_o), 64'd1);
      check("err", 64'(err_o), 64'(err_exp));
      check("done", 64'(done_o), 64'(fin_seen && mo == 0));
      check("yumi", 64'(nbf_yumi_o), 64'(nbf_v_i && idle));
      check("cmd_v", 64'(cmd_v_o), 64'(exp_cmd_v));
`ifdef BP_NBF_CHECKSUM_EN
      check("checksum", checksum_o, cs_exp);
`else
      check("checksum", checksum_o, 64'd0);
`endif
      if (cmd_v_o && exp_q.size() > 0) begin
        c = exp_q[0];
        check("cmd_addr", cmd_addr_o, c.addr);
        check("cmd_size", 64'(cmd_size_o), 64'(c.size));
        check("cmd_data", cmd_data_o, c.data);
      end
      // Model update: fence resolves on a cycle that already sees zero outstanding
      if (fence_blk && mo == 0) fence_blk = 0;
      if (acc) begin
        n_acc++;
        if (exp_q.size() > 0) begin
          cs_exp ^= exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end
      if (ack && mo == 0 && !acc) err_exp = 1;
      mo = mo + (acc ? 1 : 0) - ((ack && (mo > 0 || acc)) ? 1 : 0);
      if (nbf_v_i && nbf_yumi_o) begin
        n_yumi++;
        case (nbf_i[135:128])
          8'h00, 8'h01, 8'h02, 8'h03: begin
            c.addr = nbf_i[127:64];
            c.size = nbf_i[129:128];
            c.data = rep(nbf_i[63:0], int'(nbf_i[129:128]));
            exp_q.push_back(c);
          end
          8'hFE: begin fence_blk = 1; n_fence_yumi++; end
          8'hFF: fin_seen = 1;
          default: err_exp = 1;
        endcase
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the consuming edge
  task automatic send_pkt(input logic [7:0] op, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    nbf_i   = {$urandom, $urandom[23:0], op, a, d};
    nbf_v_i = 1'b1;
    #1;
    while (!nbf_yumi_o) begin
      if (n++ > 500) begin
        timeout("pkt_accept");
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    nbf_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 || mo != 0 || fence_blk) begin
      if (n++ > 3000) begin
        timeout("drain");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nbf_v_i = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    reset = 1'b1; nbf_v_i = 1'b0; nbf_i = '0; resp_v_i = 1'b0; cmd_ready_and_i = 1'b0;
    ack_en = 0; force_ack = 0; ack_pct = 0; rdy_pct = 0;
    n_acc = 0; n_yumi = 0; n_fence_yumi = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_cmd_v", 64'(cmd_v_o), 64'd0);
    check("rst_yumi", 64'(nbf_yumi_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_resp_ready", 64'(resp_ready_and_o), 64'd1);
    check("rst_checksum", checksum_o, 64'd0);
    @(negedge clk);

    // Full-width write, then narrow writes with garbage above the payload
    rdy_pct = 100;
    send_pkt(8'h03, 64'h0000_0000_8000_0000, 64'h1122334455667788); #1;
    check("t1_cmd_v", 64'(cmd_v_o), 64'd1);
    check("t1_addr", cmd_addr_o, 64'h0000_0000_8000_0000);
    check("t1_size", 64'(cmd_size_o), 64'd3);
    check("t1_data", cmd_data_o, 64'h1122334455667788);
    send_pkt(8'h00, 64'h0000_0000_8000_0010, 64'h5555_0000_1234_56AB); #1;
    check("t2_size8", 64'(cmd_size_o), 64'd0);
    check("t2_data8", cmd_data_o, 64'hABABABABABABABAB);
    send_pkt(8'h02, 64'h0000_0000_8000_0020, 64'h7777_6666_DEAD_BEEF); #1;
    check("t2_size32", 64'(cmd_size_o), 64'd2);
    check("t2_data32", cmd_data_o, 64'hDEADBEEF_DEADBEEF);
    @(negedge clk);
    check("t1_accepted", 64'(n_acc), 64'd3);
    ack_en = 1; ack_pct = 100;
    wait_idle();

    // Nine writes without acks: the ninth waits for a single ack
    ack_en = 0;
    base = n_acc;
    for (int i = 0; i < 9; i++) send_pkt(8'h03, 64'(i * 8), {$urandom, $urandom});
    repeat (5) @(negedge clk);
    #1;
    check("t3_held", 64'(cmd_v_o), 64'd0);
    check("t3_issued8", 64'(n_acc - base), 64'd8);
    force_ack = 1;
    @(negedge clk);
    @(negedge clk); #1;
    check("t3_ninth_v", 64'(cmd_v_o), 64'd1);
    @(negedge clk);
    check("t3_issued9", 64'(n_acc - base), 64'd9);
    ack_en = 1;
    wait_idle();

    // Three writes, fence, write with acks held off for 20 cycles
    ack_en = 0;
    base = n_acc;
    n_fence_yumi = 0;
    for (int i = 0; i < 3; i++) send_pkt(8'h01, 64'h100 + 64'(i * 2), {$urandom, $urandom});
    send_pkt(8'hFE, 64'd0, 64'd0);
    repeat (20) @(negedge clk);
    check("t4_before_ack", 64'(n_acc - base), 64'd3);
    ack_en = 1; ack_pct = 100;
    send_pkt(8'h03, 64'h200, 64'hCAFEF00D_0BADBEEF);
    wait_idle();
    check("t4_total", 64'(n_acc - base), 64'd4);
    check("t4_fence_once", 64'(n_fence_yumi), 64'd1);

    // Bad opcode, then a stray ack after reset
    send_pkt(8'h42, 64'h300, 64'h1); #1;
    check("t5_err_op", 64'(err_o), 64'd1);
    check("t5_no_cmd", 64'(cmd_v_o), 64'd0);
    do_reset(); #1;
    check("t5_err_clr", 64'(err_o), 64'd0);
    ack_en = 0;
    force_ack = 1;
    @(negedge clk);
    @(negedge clk); #1;
    check("t5_err_stray", 64'(err_o), 64'd1);
    @(negedge clk);
    base = n_acc;
    for (int i = 0; i < 8; i++) send_pkt(8'h02, 64'(i * 4), {$urandom, $urandom});
    repeat (3) @(negedge clk);
    check("t5_no_underflow", 64'(n_acc - base), 64'd8);
    ack_en = 1;
    wait_idle();

    // Random traffic
    do_reset();
    ack_pct = 40;
    for (int i = 0; i < 250; i++) begin
      int r;
      rdy_pct = $urandom_range(100, 30);
      r = $urandom_range(19);
      if (r < 18) send_pkt(8'(r % 4), {$urandom, $urandom}, {$urandom, $urandom});
      else        send_pkt(8'hFE, {$urandom, $urandom}, {$urandom, $urandom});
    end
    wait_idle();
    check("rand_err_clean", 64'(err_o), 64'd0);

    // Finish with two writes outstanding
    do_reset();
    ack_en = 0; rdy_pct = 100;
    send_pkt(8'h01, 64'h400, 64'h9999_8888_7777_1234);
    send_pkt(8'h02, 64'h408, 64'h6666_5555_0F0F_00FF);
    send_pkt(8'hFF, 64'h0, 64'h0);
    repeat (5) @(negedge clk);
    #1;
    check("t6_wait", 64'(done_o), 64'd0);
    force_ack = 1;
    @(negedge clk); #1;
    force_ack = 1;
    @(negedge clk); #1;
    check("t6_at_ack2", 64'(done_o), 64'd0);
    @(negedge clk); #1;
    check("t6_done", 64'(done_o), 64'd1);
`ifdef BP_NBF_CHECKSUM_EN
    check("t6_checksum", checksum_o, 64'h1D3B12CB1D3B12CB);
`else
    check("t6_checksum", checksum_o, 64'd0);
`endif
    base = n_yumi;
    @(negedge clk);
    nbf_i = {64'd0, 8'h03, 64'h500, 64'h1};
    nbf_v_i = 1'b1;
    repeat (20) @(negedge clk);
    nbf_v_i = 1'b0;
    #1;
    check("t6_no_yumi", 64'(n_yumi - base), 64'd0);
    check("t6_done_sticky", 64'(done_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
